// File: rtl/write_precomp.sv
// Write precompensation: timestamps each falling edge of wrdata_in and re-issues it
// D+adj+2 clocks later, shifted early/late according to the spacing of its neighbours.
module write_precomp #(
   parameter int PULSE_W = 31,
   parameter int QDEPTH  = 4
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       wrdata_in,
   input  logic       wrgate_in,
   input  logic       precomp_en,
   input  logic [3:0] precomp_amt,
   input  logic [6:0] short_thresh,
   output logic       wrdata_out,
   output logic       wrgate_out,
   output logic       busy,
   output logic       overflow
);
   localparam int AW = $clog2(QDEPTH);
   localparam int TW = $clog2(PULSE_W + 1);

   typedef struct packed {
      logic [7:0] stamp;
      logic       prev_short;
   } entry_t;

   entry_t        queue [QDEPTH];
   logic [AW:0]   rd_ptr, wr_ptr, count;
   logic [AW-1:0] head_idx, next_idx;
   logic [7:0]    ts, interval, age, delta, target;
   logic [TW-1:0] timer;
   logic          din_q, ev, fire, push, drop, drop_q, empty, full, next_short;
   logic          cfg_en;
   logic [3:0]    cfg_amt;
   logic [6:0]    cfg_thr;

   assign count      = wr_ptr - rd_ptr;
   assign empty      = (count == '0);
   assign full       = (count == (AW+1)'(QDEPTH));
   assign head_idx   = rd_ptr[AW-1:0];
   assign next_idx   = head_idx + 1'b1;
   assign ev         = din_q & ~wrdata_in;
   assign age        = ts - queue[head_idx].stamp;
   assign delta      = queue[next_idx].stamp - queue[head_idx].stamp;
   assign next_short = (count > (AW+1)'(1)) && (delta < {1'b0, cfg_thr});

   // target = D + adj, expressed as thresh + {0,1,2} * amt
   always_comb begin
      target = {1'b0, cfg_thr} + {4'd0, cfg_amt};
      if (cfg_en && queue[head_idx].prev_short && !next_short)
         target = target + {4'd0, cfg_amt};
      else if (cfg_en && !queue[head_idx].prev_short && next_short)
         target = {1'b0, cfg_thr};
   end

   assign fire       = !empty && (age == target);
   assign push       = ev && (!full || fire);
   assign drop       = ev && full && !fire;
   assign wrdata_out = (timer == '0);

   // Stamps carry +2 so that age == D+adj lands the fall at E+D+adj+2.
   always_ff @(posedge clock) begin
      if (push)
         queue[wr_ptr[AW-1:0]] <= '{stamp: ts + 8'd2, prev_short: (interval < {1'b0, cfg_thr})};
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         din_q      <= 1'b1;
         interval   <= 8'hFF;
         ts         <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         timer      <= '0;
         wrgate_out <= 1'b1;
         busy       <= 1'b0;
         overflow   <= 1'b0;
         drop_q     <= 1'b0;
         cfg_en     <= precomp_en;
         cfg_amt    <= precomp_amt;
         cfg_thr    <= short_thresh;
      end else begin
         din_q <= wrdata_in;
         ts    <= ts + 8'd1;
         if (ev)
            interval <= '0;
         else if (interval != 8'hFF)
            interval <= interval + 8'd1;
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (fire)
            rd_ptr <= rd_ptr + 1'b1;
         if (fire)
            timer <= TW'(PULSE_W);
         else if (timer != '0)
            timer <= timer - 1'b1;
         busy     <= !empty || (timer != '0);
         drop_q   <= drop;
         overflow <= overflow | drop_q;
         // gate release waits until the last precompensated pulse has finished
         if (!wrgate_in)
            wrgate_out <= 1'b0;
         else if (empty && (timer == '0) && !ev)
            wrgate_out <= 1'b1;
         if (empty && !ev) begin
            cfg_en  <= precomp_en;
            cfg_amt <= precomp_amt;
            cfg_thr <= short_thresh;
         end
      end
   end
endmodule

// File: tb/tb_write_precomp.sv
// Bench for write_precomp: directed test-plan cases plus random bursts checked
// cycle by cycle against an edge-time/queue reference model.
module tb_write_precomp;
   localparam int PW = 31;
   localparam int QD = 4;

   logic       clock = 1'b0;
   logic       reset_n, wrdata_in, wrgate_in, precomp_en;
   logic [3:0] precomp_amt;
   logic [6:0] short_thresh;
   logic       wrdata_out, wrgate_out, busy, overflow;

   write_precomp #(.PULSE_W(PW), .QDEPTH(QD)) dut (
      .clock(clock), .reset_n(reset_n), .wrdata_in(wrdata_in), .wrgate_in(wrgate_in),
      .precomp_en(precomp_en), .precomp_amt(precomp_amt), .short_thresh(short_thresh),
      .wrdata_out(wrdata_out), .wrgate_out(wrgate_out), .busy(busy), .overflow(overflow)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // reference model: pending events by edge index, pulse end by edge index
   typedef struct { int t; bit ps; } ent_t;
   ent_t q[$];
   int   n = 0, pend_end = 0, m_cnt = 255, m_amt = 0, m_thr = 0;
   bit   m_din = 1, m_gate = 1, m_busy = 0, m_ovf = 0, m_drop = 0, m_en = 0;
   bit   g = 1, last_wd = 1, last_g = 1;
   int   falls[$], rises[$], g_rise = -1;

   function automatic int fall_at(input int i);
      return (i < falls.size()) ? falls[i] : -1;
   endfunction

   task automatic step(input bit rst, input bit wd, input bit wg);
      bit was_active, ev, drop, ns, ps;
      int qs, adj;
      n++;
      if (!rst) begin
         q.delete();
         m_din = 1; m_cnt = 255; pend_end = n; m_gate = 1;
         m_busy = 0; m_ovf = 0; m_drop = 0;
         m_en = precomp_en; m_amt = precomp_amt; m_thr = short_thresh;
      end else begin
         was_active = (n - 1) < pend_end;
         qs = q.size();
         ev = m_din && !wd;
         drop = 0;
         if (qs > 0) begin
            ps = q[0].ps;
            ns = (qs > 1) && ((q[1].t - q[0].t) < m_thr);
            adj = 0;
            if (m_en && ps && !ns) adj = m_amt;
            else if (m_en && !ps && ns) adj = -m_amt;
            if (n == q[0].t + m_thr + m_amt + adj + 2) begin
               void'(q.pop_front());
               pend_end = n + PW;
            end
         end
         if (ev) begin
            if (q.size() < QD) q.push_back('{n, (m_cnt < m_thr)});
            else drop = 1;
         end
         m_cnt = ev ? 0 : ((m_cnt < 255) ? m_cnt + 1 : 255);
         m_din = wd;
         m_busy = (qs > 0) || was_active;
         m_ovf = m_ovf | m_drop;
         m_drop = drop;
         if (!wg) m_gate = 0;
         else if (qs == 0 && !was_active && !ev) m_gate = 1;
         if (qs == 0 && !ev) begin
            m_en = precomp_en; m_amt = precomp_amt; m_thr = short_thresh;
         end
      end
   endtask

   task automatic cycle(input bit rst, input bit wd, input bit wg);
      reset_n = rst; wrdata_in = wd; wrgate_in = wg;
      step(rst, wd, wg);
      @(posedge clock);
      @(negedge clock);
      chk($sformatf("wrdata@%0d", n), int'(wrdata_out), int'(!(n < pend_end)));
      chk($sformatf("busy@%0d", n), int'(busy), int'(m_busy));
      chk($sformatf("wrgate@%0d", n), int'(wrgate_out), int'(m_gate));
      chk($sformatf("ovf@%0d", n), int'(overflow), int'(m_ovf));
      if (last_wd && !wrdata_out) falls.push_back(n);
      if (!last_wd && wrdata_out) rises.push_back(n);
      if (!last_g && wrgate_out) g_rise = n;
      last_wd = wrdata_out;
      last_g = wrgate_out;
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) cycle(1'b1, 1'b1, g);
   endtask

   task automatic pulse_in(input int gap, output int e);
      cycle(1'b1, 1'b0, g);
      e = n;
      for (int i = 1; i < gap; i++) cycle(1'b1, 1'b1, g);
   endtask

   task automatic drain();
      int k;
      k = 0;
      while ((q.size() > 0 || n < pend_end) && k < 1000) begin
         cycle(1'b1, 1'b1, g);
         k++;
      end
      chk("drain_bound", int'(k < 1000), 1);
      idle(3);
   endtask

   task automatic clear_log();
      falls.delete(); rises.delete(); g_rise = -1;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int e1, e2, e3, e4, e5, e, k, gap;
      reset_n = 0; wrdata_in = 1; wrgate_in = 1;
      precomp_en = 0; precomp_amt = 4'd5; short_thresh = 7'd40;
      cycle(1'b0, 1'b1, 1'b1);
      cycle(1'b0, 1'b1, 1'b1);
      chk("rst_wrdata", int'(wrdata_out), 1);
      chk("rst_busy", int'(busy), 0);

      // precomp disabled: E+47, 31 low
      idle(300); clear_log();
      pulse_in(100, e1); pulse_in(100, e2); drain();
      chk("dis_f0", fall_at(0) - e1, 47);
      chk("dis_f1", fall_at(1) - e2, 47);
      chk("dis_w0", (rises.size() > 0 ? rises[0] : -1) - fall_at(0), 31);

      // early shift then late shift
      precomp_en = 1; idle(300); clear_log();
      pulse_in(33, e1); pulse_in(33, e2); drain();
      chk("early_f0", fall_at(0) - e1, 42);
      chk("late_f1", fall_at(1) - e2, 52);

      // middle of three short spacings is nominal
      idle(300); clear_log();
      pulse_in(33, e1); pulse_in(33, e2); pulse_in(33, e3); drain();
      chk("mid_f1", fall_at(1) - e2, 47);
      chk("mid_f2", fall_at(2) - e3, 52);

      // overflow: four fires at e1+129, +146, +148, +165 merge into one long low
      short_thresh = 7'd127; precomp_amt = 4'd15; idle(300); clear_log();
      pulse_in(2, e1); pulse_in(2, e2); pulse_in(2, e3); pulse_in(2, e4); pulse_in(2, e5);
      chk("ovf_set", int'(overflow), 1);
      drain();
      chk("ovf_nfall", falls.size(), 1);
      chk("ovf_fall", fall_at(0) - e1, 129);
      chk("ovf_rise", (rises.size() > 0 ? rises[0] : -1) - e1, 196);

      // gate hold with D=47
      cycle(1'b0, 1'b1, 1'b1);
      precomp_en = 0; short_thresh = 7'd42; precomp_amt = 4'd5;
      idle(20); g = 0; idle(5); clear_log();
      pulse_in(1, e); g = 1; drain();
      chk("gate_fall", fall_at(0) - e, 49);
      chk("gate_rise", g_rise - e, 81);

      // reset mid-operation with two pulses queued
      precomp_en = 1; short_thresh = 7'd40; idle(20); g = 0; idle(2);
      pulse_in(10, e1); pulse_in(10, e2);
      clear_log();
      cycle(1'b0, 1'b1, 1'b0);
      chk("mrst_wrdata", int'(wrdata_out), 1);
      chk("mrst_busy", int'(busy), 0);
      chk("mrst_wrgate", int'(wrgate_out), 1);
      g = 1; idle(300);
      chk("mrst_nofall", falls.size(), 0);

      // random bursts
      for (int b = 0; b < 25; b++) begin
         if ($urandom_range(3) == 0) cycle(1'b0, 1'b1, 1'b1);
         precomp_en   = 1'($urandom_range(1));
         precomp_amt  = 4'($urandom_range(15));
         short_thresh = 7'($urandom_range(127));
         idle(3);
         g = 0; idle(2);
         k = $urandom_range(6, 1);
         for (int i = 0; i < k; i++) begin
            gap = ($urandom_range(1) == 1) ? $urandom_range(120, 32) : $urandom_range(31, 2);
            pulse_in(gap, e);
         end
         g = 1; drain();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
